// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: loads a plaintext block, steps the
// shared round datapath once per cycle with AddRoundKey applied here, and returns the ciphertext.
module aes_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] rk_i,
    output logic [127:0] rnd_state_o,
    output logic         rnd_last_o,
    input  logic [127:0] rnd_result_i
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high. Ready/valid are decoded from the FSM state alone, so they never
    // depend combinationally on the partner's valid/ready.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_RND = 4'(NR);

    state_t       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [3:0]   rnd_q, rnd_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        rnd_d       = rnd_q;
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == DONE);
        data_o      = (state_q == DONE) ? st_q : '0;
        rk_idx_o    = (state_q == ROUND) ? rnd_q : 4'd0;
        rnd_last_o  = (state_q == ROUND) && (rnd_q == LAST_RND);
        rnd_state_o = st_q;

        // Flush overrides any accept, round step or output handshake.
        if (flush_i) begin
            state_d = IDLE;
            st_d    = '0;
            rnd_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        st_d    = data_i ^ rk_i;
                        rnd_d   = 4'd1;
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    st_d = rnd_result_i ^ rk_i;
                    // Terminal compare keeps the counter from ever wrapping.
                    if (rnd_q == LAST_RND) begin
                        state_d = DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                        rnd_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    st_d    = '0;
                    rnd_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: NR=10 and NR=14 instances, a behavioural AES round
// datapath and key store, and a whole-cipher reference model feeding an expected queue.
module tb_aes_round_ctrl;

    logic         clk, rst_n, flush, in_valid, out_ready, sel;
    logic [127:0] data_in;
    int           cyc, checks, failures;
    logic [127:0] exp_q[$];
    logic [127:0] last_ct;

    logic [7:0]   sbox [256];
    logic [127:0] rk10 [16];
    logic [127:0] rk14 [16];

    logic         ir_a, ov_a, rl_a, ir_b, ov_b, rl_b;
    logic [127:0] do_a, rs_a, rk_a, res_a, do_b, rs_b, rk_b, res_b;
    logic [3:0]   ri_a, ri_b;

    logic         in_ready, out_valid, rnd_last;
    logic [127:0] data_out, rnd_state;
    logic [3:0]   rk_idx;

    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_ctrl #(.NR(10)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush & ~sel),
        .in_valid_i(in_valid & ~sel), .in_ready_o(ir_a), .data_i(data_in),
        .out_valid_o(ov_a), .out_ready_i(out_ready & ~sel), .data_o(do_a),
        .rk_idx_o(ri_a), .rk_i(rk_a), .rnd_state_o(rs_a), .rnd_last_o(rl_a),
        .rnd_result_i(res_a)
    );

    aes_round_ctrl #(.NR(14)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush & sel),
        .in_valid_i(in_valid & sel), .in_ready_o(ir_b), .data_i(data_in),
        .out_valid_o(ov_b), .out_ready_i(out_ready & sel), .data_o(do_b),
        .rk_idx_o(ri_b), .rk_i(rk_b), .rnd_state_o(rs_b), .rnd_last_o(rl_b),
        .rnd_result_i(res_b)
    );

    assign in_ready  = sel ? ir_b : ir_a;
    assign out_valid = sel ? ov_b : ov_a;
    assign rnd_last  = sel ? rl_b : rl_a;
    assign data_out  = sel ? do_b : do_a;
    assign rnd_state = sel ? rs_b : rs_a;
    assign rk_idx    = sel ? ri_b : ri_a;
    assign rk_a      = rk10[ri_a];
    assign rk_b      = rk14[ri_b];

    // Clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // AES helpers on the byte-k-at-[8k+7:8k] packing
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [127:0] swap(input logic [127:0] h);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = h[127-8*k -: 8];
        return r;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] s, input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] r;
        for (int k = 0; k < 16; k++) b[k] = sbox[s[8*k +: 8]];
        for (int rr = 0; rr < 4; rr++)
            for (int c = 0; c < 4; c++) t[rr+4*c] = b[rr+4*((c+rr)%4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int k = 0; k < 16; k++) r[8*k +: 8] = t[k];
        return r;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ ((nr == 14) ? rk14[0] : rk10[0]);
        for (int r = 1; r <= nr; r++)
            s = round_fn(s, r == nr) ^ ((nr == 14) ? rk14[r] : rk10[r]);
        return s;
    endfunction

    always_comb res_a = round_fn(rs_a, rl_a);
    always_comb res_b = round_fn(rs_b, rl_b);

    task automatic build_sbox();
        logic [7:0] inv, a, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            a = inv; s = inv;
            repeat (4) begin
                a = {a[6:0], a[7]};
                s ^= a;
            end
            sbox[x] = s ^ 8'h63;
        end
    endtask

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to14);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (to14) rk14[r] = swap({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
            else      rk10[r] = swap({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        end
    endtask

    // Driver tasks
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("accept_ready", 128'(in_ready), 128'd1);
    endtask

    task automatic send_block(input logic [127:0] pt, input int stall);
        int n;
        int nr = sel ? 14 : 10;
        logic [127:0] held;
        data_in  = pt;
        in_valid = 1'b1;
        wait_ready();
        check("idle_rk_idx", 128'(rk_idx), 128'd0);
        exp_q.push_back(aes_ref(pt, nr));
        step();
        in_valid = 1'b0;
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        n = 0;
        while (!out_valid && n < 40) begin
            check("round_rk_idx", 128'(rk_idx), 128'(n+1));
            check("round_last", 128'(rnd_last), 128'(n+1 == nr));
            check("busy_ready", 128'(in_ready), 128'd0);
            step();
            n++;
        end
        check("latency", 128'(n+1), 128'(nr+1));
        held = data_out;
        for (int i = 0; i < stall; i++) begin
            check("bp_valid", 128'(out_valid), 128'd1);
            check("bp_data", data_out, held);
            check("bp_ready", 128'(in_ready), 128'd0);
            check("done_rk_idx", 128'(rk_idx), 128'd0);
            step();
        end
        out_ready = 1'b1;
        check("out_valid", 128'(out_valid), 128'd1);
        last_ct = data_out;
        if (exp_q.size() > 0) check("cipher", data_out, exp_q.pop_front());
        else check("cipher_unexpected", data_out, 128'd0);
        step();
        out_ready = 1'b0;
        check("post_ready", 128'(in_ready), 128'd1);
        check("post_valid", 128'(out_valid), 128'd0);
        check("post_data", data_out, 128'd0);
    endtask

    task automatic start_and_wait_round(input int idx);
        int n = 0;
        data_in  = swap(PT_C);
        in_valid = 1'b1;
        wait_ready();
        step();
        in_valid = 1'b0;
        while (rk_idx != 4'(idx) && n < 20) begin step(); n++; end
        check("reach_round", 128'(rk_idx), 128'(idx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_data_o"}, data_out, 128'd0);
        check({tag, "_rk_idx"}, 128'(rk_idx), 128'd0);
        check({tag, "_rnd_state"}, rnd_state, 128'd0);
        check({tag, "_rnd_last"}, 128'(rnd_last), 128'd0);
    endtask

    task automatic back_to_back();
        int acc [2];
        int accepts = 0, outs = 0, n = 0;
        bit acc_now, out_now;
        data_in   = {$urandom, $urandom, $urandom, $urandom};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (outs < 2 && n < 80) begin
            acc_now = in_valid && in_ready;
            out_now = out_valid && out_ready;
            if (acc_now) begin
                acc[accepts] = cyc;
                exp_q.push_back(aes_ref(data_in, 10));
            end
            if (out_now) begin
                outs++;
                if (exp_q.size() > 0) check("b2b_cipher", data_out, exp_q.pop_front());
                else check("b2b_unexpected", data_out, 128'd0);
            end
            step();
            n++;
            if (acc_now) begin
                accepts++;
                if (accepts == 1) data_in = {$urandom, $urandom, $urandom, $urandom};
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        check("b2b_outs", 128'(outs), 128'd2);
        check("b2b_gap", 128'(acc[1] - acc[0]), 128'd12);
    endtask

    initial begin
        int pulses;
        cyc = 0; checks = 0; failures = 0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0;
        data_in = '0; last_ct = '0;
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10, 1'b0);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14, 1'b1);
        #12;
        check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;
        step();

        // FIPS-197 C.1 with immediate ready, then with 5 cycles of back-pressure
        send_block(swap(PT_C), 0);
        check("c1_kat", last_ct, swap(CT_C1));
        send_block(swap(PT_C), 5);
        check("c1_bp_kat", last_ct, swap(CT_C1));

        back_to_back();

        // Flush at round 4
        start_and_wait_round(4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_reset_outputs("flush");
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) pulses++;
            step();
        end
        check("flush_no_valid", 128'(pulses), 128'd0);
        send_block(swap(PT_C), 1);
        check("flush_after_kat", last_ct, swap(CT_C1));

        // Asynchronous reset mid-round, away from the clock edge
        start_and_wait_round(5);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk) rst_n = 1'b1;
        step();
        send_block(swap(PT_C), 0);
        check("rst_after_kat", last_ct, swap(CT_C1));

        // Randomized traffic on NR=10
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
        end

        // FIPS-197 C.3 and randomized traffic on NR=14
        sel = 1'b1;
        step();
        send_block(swap(PT_C), 0);
        check("c3_kat", last_ct, swap(CT_C3));
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 2)) step();
            send_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3));
        end

        check("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative AES encryption round sequencer. It accepts one 128-bit plaintext block over a valid/ready handshake and holds the cipher state in a register. It drives the shared round datapath (SubBytes → ShiftRows → MixColumn, with MixColumn bypassed on the last round) once per cycle, applies AddRoundKey internally and returns the ciphertext over a second valid/ready handshake. Round keys come from an external key store, indexed by the controller.

## Interface
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256)
- clk_i  in  1  clock, all state updates on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- flush_i  in  1  synchronous abort; returns the block to IDLE
- in_valid_i  in  1  plaintext valid
- in_ready_o  out  1  controller can accept plaintext
- data_i  in  128  plaintext; byte k at [8k+7:8k], column-major state order (bytes 0-3 form column 0)
- out_valid_o  out  1  ciphertext valid
- out_ready_i  in  1  consumer accepts ciphertext
- data_o  out  128  ciphertext, same byte order as data_i
- rk_idx_o  out  4  round-key index requested from the key store
- rk_i  in  128  round key for rk_idx_o, combinational from the store, same cycle
- rnd_state_o  out  128  current state fed to the round datapath
- rnd_last_o  out  1  final round; datapath bypasses MixColumn
- rnd_result_i  in  128  combinational datapath result, without AddRoundKey

## Operation
- State register st (128 b), round counter rnd (4 b), FSM {IDLE, ROUND, DONE}.
- IDLE:
  - in_ready_o=1, rk_idx_o=0.
  - On in_valid_i: st ← data_i ^ rk_i, rnd ← 1, go to ROUND.
- ROUND:
  - rk_idx_o=rnd, rnd_state_o=st, rnd_last_o=(rnd==NR).
  - Each cycle: st ← rnd_result_i ^ rk_i.
  - If rnd==NR, go to DONE; otherwise rnd ← rnd+1.
- DONE:
  - out_valid_o=1, data_o=st.
  - Hold st and out_valid_o until out_ready_i; on the handshake, go to IDLE and clear rnd to 0.
- rnd_state_o=st in every state. rnd_last_o=0 outside ROUND. rk_idx_o=0 in IDLE and DONE.
- data_o is driven from st only in DONE; it is 0 otherwise.
- flush_i has priority over every transition:
  - next state IDLE, rnd ← 0, st ← 0.
  - No output handshake completes in a flush cycle, even if out_ready_i=1.
- The counter never wraps. The NR terminal compare stops it; rnd ≤ 14 fits in 4 bits.
- Plaintext is never accepted while busy: in_ready_o=0 in ROUND and DONE.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, data_o=0, rk_idx_o=0, rnd_state_o=0, rnd_last_o=0. Internally st=0, rnd=0, FSM=IDLE.
- Accept at edge T0 → ROUND for rounds 1..NR on cycles T0+1..T0+NR → out_valid_o high from T0+NR+1.
- Latency from accept to out_valid_o is NR+1 cycles (11 for NR=10).
- Maximum throughput is one block per NR+2 cycles: one DONE cycle with immediate out_ready_i, then one IDLE accept cycle.
- Back-pressure: with out_ready_i low, DONE holds indefinitely with data_o stable.
- Reset asserted mid-operation forces reset values immediately. After release, the first rising edge sees IDLE.
- All outputs except data_o and rnd_* are registered or decoded from FSM state only. There is no input-to-output combinational path on the handshake signals.

## Test plan
- FIPS-197 C.1 (NR=10):
  - Stimulus: key 000102…0f in the store, reference round model on rnd_result_i, plaintext 00112233445566778899aabbccddeeff.
  - Required: data_o=69c4e0d86a7b0430d8cdb78070b4c55a; out_valid_o rises exactly 11 cycles after accept; rk_idx_o steps 0,1,…,10; rnd_last_o high only with rk_idx_o=10.
- Back-pressure:
  - Stimulus: C.1 vector with out_ready_i held low for 5 cycles.
  - Required: out_valid_o=1 and data_o stable for all 5 cycles; in_ready_o=0 throughout; IDLE one cycle after the handshake.
- Back-to-back:
  - Stimulus: in_valid_i held high with two blocks, out_ready_i=1.
  - Required: the second accept occurs 12 cycles after the first; both ciphertexts are correct.
- Flush:
  - Stimulus: assert flush_i at round 4 of C.1.
  - Required: next cycle in IDLE with in_ready_o=1 and rnd_state_o=0; no out_valid_o pulse. A following C.1 block completes correctly.
- Async reset:
  - Stimulus: pull rst_ni low mid-round, away from a clock edge.
  - Required: outputs take reset values before the next edge; a C.1 block after release completes correctly.
- FIPS-197 C.3 (NR=14):
  - Stimulus: 256-bit key 00…1f expanded into the store, same plaintext.
  - Required: data_o=8ea2b7ca516745bfeafc49904b496089; latency 15 cycles.
